// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   STG_*            : bit index of each stall class in stall/flush vectors
//   redirect_state_e : redirect flush sequencer states
//   stall_vec_t      : one bit per stall class, bit 0 = fetch
//   cnt_width()      : width needed to hold 0..max
package hazard_pkg;

  localparam int unsigned STG_FETCH = 0;
  localparam int unsigned STG_FE    = 1;
  localparam int unsigned STG_BE    = 2;
  localparam int unsigned STG_RET   = 3;

  typedef enum logic [0:0] {IDLE, FLUSH} redirect_state_e;

  typedef logic [3:0] stall_vec_t;

  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Saturating outstanding-request counter for one memory channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : request issued (dropped when already at MAX)
//   dec        : response/ack returned (ignored when at 0)
//   count      : current outstanding count
//   full       : count == MAX
//   underflow  : dec with nothing outstanding (and no same-cycle inc)
module outstanding_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MAX  = 4,
  parameter int unsigned CntW = cnt_width(MAX)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            dec,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            underflow
);

  logic [CntW-1:0] count_q, count_d;

  assign count     = count_q;
  assign full      = (count_q == CntW'(MAX));
  assign underflow = dec & ~inc & (count_q == '0);

  // A same-cycle inc and dec cancel, even at the limits.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + CntW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller for the out-of-order core.
//   clk, reset         : clock, asynchronous active-low reset
//   icache_busy, fetch_valid, rob_full : front-end hazard sources
//   redirect           : PC overwrite, starts/restarts a multi-cycle flush
//   dreq/dresp/dmiss   : per data-port request, response and miss
//   wreq/wack          : per write-port issue and completion
//   stall, flush       : {retire, backend, frontend, fetch}, bit 0 = fetch
//   dport_full         : data port at its outstanding limit
//   proto_err          : sticky, overflowing request or orphan response/ack
//   perf_*             : stall/redirect counters, present only when STALL_PERF_EN
//                        is defined, otherwise tied to zero
module stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_DPORTS   = 2,
  parameter int unsigned NUM_WPORTS   = 1,
  parameter int unsigned MAX_DOUT     = 4,
  parameter int unsigned MAX_WOUT     = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_busy,
  input  logic                  redirect,
  input  logic                  fetch_valid,
  input  logic                  rob_full,
  input  logic [NUM_DPORTS-1:0] dreq,
  input  logic [NUM_DPORTS-1:0] dresp,
  input  logic [NUM_DPORTS-1:0] dmiss,
  input  logic [NUM_WPORTS-1:0] wreq,
  input  logic [NUM_WPORTS-1:0] wack,
  output stall_vec_t            stall,
  output stall_vec_t            flush,
  output logic [NUM_DPORTS-1:0] dport_full,
  output logic                  proto_err,
  output logic [CNT_W-1:0]      perf_fetch,
  output logic [CNT_W-1:0]      perf_fe,
  output logic [CNT_W-1:0]      perf_be,
  output logic [CNT_W-1:0]      perf_ret,
  output logic [CNT_W-1:0]      perf_redirects
);

  localparam int unsigned DCntW  = cnt_width(MAX_DOUT);
  localparam int unsigned WCntW  = cnt_width(MAX_WOUT);
  localparam int unsigned FcntW  = cnt_width(FLUSH_CYCLES);

  logic [NUM_DPORTS-1:0] d_under, d_over;
  logic [NUM_WPORTS-1:0] w_full, w_under, w_over;

  for (genvar i = 0; i < NUM_DPORTS; i++) begin : g_dport
    logic [DCntW-1:0] cnt;
    outstanding_counter #(.MAX(MAX_DOUT)) u_cnt (
      .clk      (clk),
      .rst_n    (reset),
      .inc      (dreq[i]),
      .dec      (dresp[i]),
      .count    (cnt),
      .full     (dport_full[i]),
      .underflow(d_under[i])
    );
    assign d_over[i] = dreq[i] & ~dresp[i] & (cnt == DCntW'(MAX_DOUT));
  end

  for (genvar i = 0; i < NUM_WPORTS; i++) begin : g_wport
    logic [WCntW-1:0] cnt;
    outstanding_counter #(.MAX(MAX_WOUT)) u_cnt (
      .clk      (clk),
      .rst_n    (reset),
      .inc      (wreq[i]),
      .dec      (wack[i]),
      .count    (cnt),
      .full     (w_full[i]),
      .underflow(w_under[i])
    );
    assign w_over[i] = wreq[i] & ~wack[i] & (cnt == WCntW'(MAX_WOUT));
  end

  // Redirect sequencer and sticky protocol error
  redirect_state_e  state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic             proto_err_q, proto_err_d;
  logic             flush_active;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d = FLUSH;
          fcnt_d  = FcntW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (redirect) begin
          fcnt_d = FcntW'(FLUSH_CYCLES - 1);
        end else if (fcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - FcntW'(1);
        end
      end
    endcase
  end

  assign proto_err_d = proto_err_q | (|d_under) | (|d_over) | (|w_under) | (|w_over);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign flush_active = (state_q == FLUSH) | redirect;
  assign proto_err    = proto_err_q;

  // Later stages back-pressure earlier ones; retire never propagates upward.
  always_comb begin
    stall = '0;
    flush = '0;
    stall[STG_RET]   = (|w_full) | (|wack);
    stall[STG_BE]    = (|dmiss) | (|dport_full);
    stall[STG_FE]    = rob_full | stall[STG_BE];
    stall[STG_FETCH] = icache_busy | ~fetch_valid | rob_full | stall[STG_FE] | flush_active;
    flush[STG_FETCH] = flush_active;
    flush[STG_FE]    = flush_active;
    if (!reset) begin
      stall = '1;
      flush = '1;
    end
  end

`ifdef STALL_PERF_EN
  logic [4:0]       perf_ev;
  logic [CNT_W-1:0] perf_q [5];
  logic [CNT_W-1:0] perf_d [5];

  assign perf_ev = {redirect, stall};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      perf_d[i] = perf_q[i];
      if (perf_ev[i] && (perf_q[i] != '1)) begin
        perf_d[i] = perf_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) perf_q[i] <= perf_d[i];
    end
  end

  assign perf_fetch     = perf_q[0];
  assign perf_fe        = perf_q[1];
  assign perf_be        = perf_q[2];
  assign perf_ret       = perf_q[3];
  assign perf_redirects = perf_q[4];
`else
  assign perf_fetch     = '0;
  assign perf_fe        = '0;
  assign perf_be        = '0;
  assign perf_ret       = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// Scoreboard bench for stall_controller: stimulus pushes expected outputs computed by a
// rule-level reference model; a negedge monitor pops and compares.
module tb_stall_controller;

  localparam int unsigned NUM_DPORTS   = 2;
  localparam int unsigned NUM_WPORTS   = 1;
  localparam int unsigned MAX_DOUT     = 4;
  localparam int unsigned MAX_WOUT     = 2;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 32;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  icache_busy = 1'b0, redirect = 1'b0, fetch_valid = 1'b1, rob_full = 1'b0;
  logic [NUM_DPORTS-1:0] dreq = '0, dresp = '0, dmiss = '0;
  logic [NUM_WPORTS-1:0] wreq = '0, wack = '0;
  logic [3:0]            stall, flush;
  logic [NUM_DPORTS-1:0] dport_full;
  logic                  proto_err;
  logic [CNT_W-1:0]      perf_fetch, perf_fe, perf_be, perf_ret, perf_redirects;

  stall_controller #(
    .NUM_DPORTS  (NUM_DPORTS),
    .NUM_WPORTS  (NUM_WPORTS),
    .MAX_DOUT    (MAX_DOUT),
    .MAX_WOUT    (MAX_WOUT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .icache_busy   (icache_busy),
    .redirect      (redirect),
    .fetch_valid   (fetch_valid),
    .rob_full      (rob_full),
    .dreq          (dreq),
    .dresp         (dresp),
    .dmiss         (dmiss),
    .wreq          (wreq),
    .wack          (wack),
    .stall         (stall),
    .flush         (flush),
    .dport_full    (dport_full),
    .proto_err     (proto_err),
    .perf_fetch    (perf_fetch),
    .perf_fe       (perf_fe),
    .perf_be       (perf_be),
    .perf_ret      (perf_ret),
    .perf_redirects(perf_redirects)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]                 stall;
    logic [3:0]                 flush;
    logic [NUM_DPORTS-1:0]      df;
    logic                       perr;
    logic [4:0][CNT_W-1:0]      pf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int          dc [NUM_DPORTS];
  int          wc [NUM_WPORTS];
  bit          err;
  int          flush_left;   // cycles of flush still owed after the current one
  longint      perf_m [5];

  task automatic model_clear();
    foreach (dc[i]) dc[i] = 0;
    foreach (wc[i]) wc[i] = 0;
    err = 0;
    flush_left = 0;
    for (int i = 0; i < 5; i++) perf_m[i] = 0;
  endtask

  task automatic model_step();
    exp_t   e;
    bit     fa, wfull, anydf, fetch_raw;
    e = '0;
    if (!reset) begin
      e.stall = 4'hF;
      e.flush = 4'hF;
      sb.push_back(e);
      model_clear();
      return;
    end
    wfull = 0;
    anydf = 0;
    foreach (wc[i]) if (wc[i] == MAX_WOUT) wfull = 1;
    foreach (dc[i]) begin
      e.df[i] = (dc[i] == MAX_DOUT);
      if (e.df[i]) anydf = 1;
    end
    fa        = redirect || (flush_left > 0);
    fetch_raw = icache_busy || !fetch_valid || rob_full;
    e.stall[3] = wfull || (wack != 0);
    e.stall[2] = (dmiss != 0) || anydf;
    e.stall[1] = rob_full || e.stall[2];
    e.stall[0] = fetch_raw || e.stall[1] || fa;
    e.flush    = {2'b00, fa, fa};
    e.perr     = err;
`ifdef STALL_PERF_EN
    for (int i = 0; i < 5; i++) e.pf[i] = CNT_W'(perf_m[i]);
`endif
    sb.push_back(e);
    // advance state for the next cycle
    for (int i = 0; i < NUM_DPORTS; i++) begin
      if (dreq[i] && !dresp[i]) begin
        if (dc[i] < MAX_DOUT) dc[i]++; else err = 1;
      end else if (dresp[i] && !dreq[i]) begin
        if (dc[i] > 0) dc[i]--; else err = 1;
      end
    end
    for (int i = 0; i < NUM_WPORTS; i++) begin
      if (wreq[i] && !wack[i]) begin
        if (wc[i] < MAX_WOUT) wc[i]++; else err = 1;
      end else if (wack[i] && !wreq[i]) begin
        if (wc[i] > 0) wc[i]--; else err = 1;
      end
    end
    if (redirect) flush_left = FLUSH_CYCLES;
    else if (flush_left > 0) flush_left--;
    for (int i = 0; i < 4; i++) if (e.stall[i]) perf_m[i]++;
    if (redirect) perf_m[4]++;
    for (int i = 0; i < 5; i++)
      if (perf_m[i] > longint'({CNT_W{1'b1}})) perf_m[i] = longint'({CNT_W{1'b1}});
  endtask

  task automatic drive(input logic rs, fv, ib, rd, rf,
                       input logic [NUM_DPORTS-1:0] dq, dr, dm,
                       input logic [NUM_WPORTS-1:0] wq, wa);
    @(posedge clk);
    #1;
    reset = rs; fetch_valid = fv; icache_busy = ib; redirect = rd; rob_full = rf;
    dreq = dq; dresp = dr; dmiss = dm; wreq = wq; wack = wa;
    model_step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall", 64'(stall), 64'(e.stall));
      chk("flush", 64'(flush), 64'(e.flush));
      chk("dport_full", 64'(dport_full), 64'(e.df));
      chk("proto_err", 64'(proto_err), 64'(e.perr));
      chk("perf_fetch", 64'(perf_fetch), 64'(e.pf[0]));
      chk("perf_fe", 64'(perf_fe), 64'(e.pf[1]));
      chk("perf_be", 64'(perf_be), 64'(e.pf[2]));
      chk("perf_ret", 64'(perf_ret), 64'(e.pf[3]));
      chk("perf_redirects", 64'(perf_redirects), 64'(e.pf[4]));
    end
  end

  initial begin
    logic rs;
    model_clear();
    // reset held, then released
    repeat (3) drive(0, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // data port 0 limit, then one response
    repeat (5) drive(1, 1, 0, 0, 0, 2'b01, '0, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, 2'b01, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // single redirect, then back-to-back redirects
    drive(1, 1, 0, 1, 0, '0, '0, '0, '0, '0);
    repeat (4) drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    drive(1, 1, 0, 1, 0, '0, '0, '0, '0, '0);
    drive(1, 1, 0, 1, 0, '0, '0, '0, '0, '0);
    repeat (4) drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // reset aborts a flush, then clean start
    drive(1, 1, 0, 1, 0, '0, '0, '0, '0, '0);
    drive(0, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // port 1 to count 2, simultaneous req/resp, then drain and underflow
    repeat (2) drive(1, 1, 0, 0, 0, 2'b10, '0, '0, '0, '0);
    drive(1, 1, 0, 0, 0, 2'b10, 2'b10, '0, '0, '0);
    repeat (2) drive(1, 1, 0, 0, 0, '0, 2'b10, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, 2'b10, '0, '0, '0);
    repeat (3) drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    drive(0, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // rob_full alone; wack alone; write port fill
    drive(1, 1, 0, 0, 1, '0, '0, '0, '0, '0);
    drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '1);
    repeat (3) drive(1, 1, 0, 0, 0, '0, '0, '0, '1, '0);
    drive(0, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // ten cycles of dmiss on port 0
    repeat (10) drive(1, 1, 0, 0, 0, '0, '0, 2'b01, '0, '0);
    drive(1, 1, 0, 0, 0, '0, '0, '0, '0, '0);
    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      rs = ($urandom_range(0, 99) != 0);
      drive(rs,
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0),
            NUM_DPORTS'($urandom),
            NUM_DPORTS'($urandom) & NUM_DPORTS'($urandom),
            ($urandom_range(0, 9) == 0) ? NUM_DPORTS'($urandom) : '0,
            NUM_WPORTS'($urandom_range(0, 2) == 0),
            NUM_WPORTS'($urandom_range(0, 2) == 0));
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_controller.md
Name: stall_controller

Overview:
- Parametrised pipeline stall/flush controller for the out-of-order core.
- Produces per-class stall and flush controls for fetch, frontend, backend and retire.
- Tracks outstanding data-cache and write-buffer requests on multiple channels.
- Sequences a multi-cycle redirect flush and applies back-pressure from later stages to earlier ones.

Parameters:
- NUM_DPORTS, 2, number of data-cache load channels tracked
- NUM_WPORTS, 1, number of store/write-buffer channels tracked
- MAX_DOUT, 4, max outstanding requests per data port
- MAX_WOUT, 2, max outstanding writes per write port
- FLUSH_CYCLES, 2, cycles flush is held after a redirect (>=1)
- CNT_W, 32, perf counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- icache_busy  in  1  instruction cache cannot return this cycle
- redirect  in  1  PC overwrite (branch mispredict/exception)
- fetch_valid  in  1  fetched instruction word is non-zero
- rob_full  in  1  ROB has no free entry
- dreq  in  NUM_DPORTS  data request issued per port
- dresp  in  NUM_DPORTS  data response returned per port
- dmiss  in  NUM_DPORTS  data miss reported this cycle
- wreq  in  NUM_WPORTS  write issued per port
- wack  in  NUM_WPORTS  write completed per port
- stall  out  4  {retire, backend, frontend, fetch}; bit 0 = fetch
- flush  out  4  same bit order
- dport_full  out  NUM_DPORTS  port at MAX_DOUT
- proto_err  out  1  sticky: response or ack with zero outstanding
- perf_fetch, perf_fe, perf_be, perf_ret, perf_redirects  out  CNT_W each  perf counters

Behaviour:
- While reset is low:
  - all stall bits = 1, all flush bits = 1.
  - Counters = 0, proto_err = 0, FSM = IDLE.
  - dport_full = 0.
- Outstanding counters, one per port:
  - Width $clog2(MAX+1).
  - dreq only increments when the count is below MAX_DOUT. dreq at MAX is dropped and also sets proto_err.
  - dresp decrements.
  - dreq and dresp in the same cycle: count unchanged.
  - dresp at 0: count stays 0 and proto_err is set.
  - Write ports follow the same rules with MAX_WOUT, wreq and wack.
- Raw stall terms, combinational, zero latency:
  - fetch_raw = icache_busy | !fetch_valid | rob_full
  - fe_raw = rob_full
  - be_raw = |dmiss | |dport_full
  - ret_raw = any write port count == MAX_WOUT | |wack
- Back-pressure:
  - stall[3] = ret_raw
  - stall[2] = be_raw
  - stall[1] = fe_raw | stall[2]
  - stall[0] = fetch_raw | stall[1] | flush_active
  - Retire does not propagate upward.
- Redirect FSM:
  - States: IDLE, FLUSH.
  - IDLE + redirect: go to FLUSH and load fcnt = FLUSH_CYCLES-1.
  - flush[0] and flush[1] assert combinationally in the redirect cycle and on every FLUSH cycle.
  - FLUSH: decrement fcnt; at 0 return to IDLE.
  - redirect while in FLUSH reloads fcnt (restart). Total flush length = FLUSH_CYCLES after the last redirect.
  - flush_active = (state == FLUSH) | redirect.
  - flush[3:2] = 0 outside reset.
- flush does not clear stall; a stage may see both asserted and treats flush as higher priority.
- Outputs are combinational from inputs and registered state; the only registered state is the counters, the FSM and proto_err.
- A reset assertion mid-flush aborts it immediately and asynchronously.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - Each perf_* counter increments by 1 per clk with its corresponding stall bit high.
  - perf_redirects increments on each redirect pulse.
  - Counters saturate at all-ones and clear on reset.
- Undefined: perf_* ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- hazard_pkg holds:
  - stall class index localparams STG_FETCH = 0, STG_FE = 1, STG_BE = 2, STG_RET = 3
  - redirect_state_e enum {IDLE, FLUSH}
  - stall_vec_t typedef logic[3:0]
- Sub-module outstanding_counter (params MAX), instantiated once per dport and wport.
  - Inputs: inc, dec.
  - Outputs: count, full, underflow.

Test Plan:
- Reset low for 3 cycles then released, with fetch_valid = 1 and all else 0 -> stall = 4'b1111 and flush = 4'b1111 during reset; stall = 0 and flush = 0 on the first cycle after release.
- Data port 0 limit: 4 dreq on port 0, then a 5th dreq -> dport_full[0] = 1 after the 4th; stall = 4'b0111; count stays 4; proto_err = 1. Then 1 dresp -> stall = 0.
- Redirect with FLUSH_CYCLES = 2: single redirect pulse at cycle t -> flush[1:0] = 2'b11 at t, t+1, t+2; 0 at t+3. Second redirect at t+1 -> flush held through t+3.
- Simultaneous dreq + dresp on port 1 at count 2 -> count stays 2, no proto_err. dresp at count 0 -> proto_err sticky until reset.
- rob_full = 1 alone -> stall = 4'b0011. wack pulse alone -> stall = 4'b1000; fetch is not stalled.
- With STALL_PERF_EN: 10 cycles of dmiss[0] -> perf_be = 10, perf_fe = 10, perf_fetch = 10, perf_ret = 0.
